// File: rtl/apb_timer_slave.sv
// APB timer slave: a prescaled 32-bit down-counter with auto-reload and a level irq.
// Ports: Hclk/Hresetn, APB Pselx/Penable/Pwrite/Paddr/Pwdata -> Prdata, irq out.
module apb_timer_slave #(
    parameter int SLV_IDX = 0,
    parameter int PRE_W   = 8
) (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic [2:0]  Pselx,
    input  logic        Penable,
    input  logic        Pwrite,
    input  logic [31:0] Paddr,
    input  logic [31:0] Pwdata,
    output logic [31:0] Prdata,
    output logic        irq
);

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_LOAD   = 3'd1;
    localparam logic [2:0] A_VALUE  = 3'd2;
    localparam logic [2:0] A_STATUS = 3'd3;
    localparam logic [2:0] A_PRE    = 3'd4;

    logic             en_q, en_d;
    logic             auto_q, auto_d;
    logic             ie_q, ie_d;
    logic             pend_q, pend_d;
    logic [31:0]      load_q, load_d;
    logic [31:0]      value_q, value_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;

    logic       sel;
    logic       wr;
    logic       rd;
    logic       ctrl_wr;
    logic       tick;
    logic [2:0] addr;
    logic       unused;

    assign sel     = Pselx[SLV_IDX];
    assign addr    = Paddr[4:2];
    assign wr      = sel & Penable & Pwrite;
    assign rd      = sel & ~Penable & ~Pwrite;
    assign ctrl_wr = wr && (addr == A_CTRL);
    assign tick    = en_q && (pre_cnt_q == pre_q);
    assign unused  = ^{Pselx, Paddr[31:5], Paddr[1:0]};

    always_comb begin
        en_d      = en_q;
        auto_d    = auto_q;
        ie_d      = ie_q;
        pend_d    = pend_q;
        load_d    = load_q;
        value_d   = value_q;
        rdata_d   = rdata_q;
        pre_d     = pre_q;
        pre_cnt_d = pre_cnt_q;

        if (!en_q || tick) begin
            pre_cnt_d = '0;
        end else begin
            pre_cnt_d = pre_cnt_q + 1'b1;
        end

        // Clear before the underflow set so a same-cycle set survives.
        if (wr && (addr == A_STATUS) && Pwdata[0]) begin
            pend_d = 1'b0;
        end

        // A CTRL write in the same cycle swallows the tick.
        if (tick && !ctrl_wr) begin
            if (value_q != 32'd0) begin
                value_d = value_q - 32'd1;
            end else begin
                pend_d = 1'b1;
                if (auto_q) begin
                    value_d = load_q;
                end else begin
                    en_d = 1'b0;
                end
            end
        end

        if (wr) begin
            case (addr)
                A_CTRL: begin
                    en_d   = Pwdata[0];
                    auto_d = Pwdata[1];
                    ie_d   = Pwdata[2];
                    if (!en_q && Pwdata[0]) begin
                        value_d   = load_q;
                        pre_cnt_d = '0;
                    end
                end
                A_LOAD:  load_d = Pwdata;
                A_PRE:   pre_d  = Pwdata[PRE_W-1:0];
                default: ;
            endcase
        end

        // Captured at the end of setup; holds through enable.
        if (rd) begin
            case (addr)
                A_CTRL:   rdata_d = {29'd0, ie_q, auto_q, en_q};
                A_LOAD:   rdata_d = load_q;
                A_VALUE:  rdata_d = value_q;
                A_STATUS: rdata_d = {31'd0, pend_q};
                A_PRE:    rdata_d = {{(32-PRE_W){1'b0}}, pre_q};
                default:  rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            en_q      <= 1'b0;
            auto_q    <= 1'b0;
            ie_q      <= 1'b0;
            pend_q    <= 1'b0;
            load_q    <= '0;
            value_q   <= '0;
            rdata_q   <= '0;
            pre_q     <= '0;
            pre_cnt_q <= '0;
        end else begin
            en_q      <= en_d;
            auto_q    <= auto_d;
            ie_q      <= ie_d;
            pend_q    <= pend_d;
            load_q    <= load_d;
            value_q   <= value_d;
            rdata_q   <= rdata_d;
            pre_q     <= pre_d;
            pre_cnt_q <= pre_cnt_d;
        end
    end

    assign Prdata = rdata_q;
    assign irq    = pend_q & ie_q;

endmodule
